// File: rtl/ld_st_dep_tracker_pkg.sv
// Shared types for the load/store dependence tracker: access width encoding
// and the byte-lane mask derived from (addr[1:0], width).
package ld_st_pkg;

  typedef enum logic [1:0] {
    LS_B = 2'b00,
    LS_H = 2'b01,
    LS_W = 2'b10
  } ls_width_e;

  // Width code 2'b11 is treated as a full word.
  function automatic logic [3:0] bmask(input logic [1:0] a, input logic [1:0] w);
    logic [3:0] m;
    case (ls_width_e'(w))
      LS_B:    m = 4'b0001 << a;
      LS_H:    m = 4'b0011 << a;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ld_st_dep_tracker_youngest_dep_sel.sv
// Finds the youngest set column of one MDM row: the set bit nearest below the
// store FIFO tail, by rotating the row so tail-1 lands at bit 0.
module youngest_dep_sel #(
  parameter int N  = 8,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  row,
  input  logic [LW-1:0] tail,
  output logic          found,
  output logic [LW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [LW-1:0] k_sel;

  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = row[tail - LW'(k + 1)];
    end
  end

  always_comb begin
    found = 1'b0;
    k_sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        k_sel = LW'(k);
      end
    end
    idx = tail - k_sel - LW'(1);
  end

endmodule

// File: rtl/ld_st_dep_tracker.sv
// Load buffer + store FIFO with a load-x-store dependence matrix; loads wait for
// older overlapping stores to drain, or issue early with forwarded store data.
module ld_st_dep_tracker
  import ld_st_pkg::*;
#(
  parameter int LD_N_ENTRIES = 8,
  parameter int ST_N_ENTRIES = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 6,
  parameter bit FWD_EN       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    ld_enq_valid,
  output logic                    ld_enq_ready,
  input  logic [ADDR_WIDTH-1:0]   ld_enq_addr,
  input  logic [1:0]              ld_enq_width,
  input  logic [ROB_ID_WIDTH-1:0] ld_enq_rob_id,
  input  logic                    st_enq_valid,
  output logic                    st_enq_ready,
  input  logic [ADDR_WIDTH-1:0]   st_enq_addr,
  input  logic [1:0]              st_enq_width,
  input  logic [31:0]             st_enq_data,
  output logic                    st_deq_valid,
  input  logic                    st_deq_ready,
  output logic [ADDR_WIDTH-1:0]   st_deq_addr,
  output logic [1:0]              st_deq_width,
  output logic [31:0]             st_deq_data,
  output logic                    ld_iss_valid,
  input  logic                    ld_iss_ready,
  output logic [ADDR_WIDTH-1:0]   ld_iss_addr,
  output logic [1:0]              ld_iss_width,
  output logic [ROB_ID_WIDTH-1:0] ld_iss_rob_id,
  output logic                    ld_iss_fwd,
  output logic [31:0]             ld_iss_fwd_data
);

  localparam int SP = $clog2(ST_N_ENTRIES);
  localparam int LP = $clog2(LD_N_ENTRIES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic [1:0]              width;
    logic [ROB_ID_WIDTH-1:0] rob_id;
  } ld_buf_entry_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            width;
    logic [31:0]           data;
  } st_buf_entry_t;

  logic [LD_N_ENTRIES-1:0] ld_valid;
  ld_buf_entry_t           ld_buf [LD_N_ENTRIES];
  st_buf_entry_t           st_buf [ST_N_ENTRIES];
  logic [SP:0]             st_head, st_tail;
  logic [ST_N_ENTRIES-1:0] mdm [LD_N_ENTRIES];

  logic [SP-1:0]           head_idx, tail_idx;
  logic [SP:0]             st_count;
  logic                    st_full;
  logic [ST_N_ENTRIES-1:0] st_col_valid, deq_col, new_row;
  logic                    ld_enq_fire, st_enq_fire, st_deq_fire, ld_iss_fire;
  logic [LP-1:0]           ld_free_slot, iss_sel;
  logic [LD_N_ENTRIES-1:0] y_found, fwd_ok, ld_ready;
  logic [SP-1:0]           y_idx [LD_N_ENTRIES];
  logic [3:0]              ld_enq_bmask;

  assign head_idx = st_head[SP-1:0];
  assign tail_idx = st_tail[SP-1:0];
  assign st_count = st_tail - st_head;
  assign st_full  = (st_head[SP] != st_tail[SP]) && (head_idx == tail_idx);

  assign st_enq_ready = ~st_full;
  assign st_enq_fire  = st_enq_valid & ~st_full;
  assign st_deq_valid = (st_head != st_tail);
  assign st_deq_fire  = st_deq_valid & st_deq_ready;
  assign st_deq_addr  = st_buf[head_idx].addr;
  assign st_deq_width = st_buf[head_idx].width;
  assign st_deq_data  = st_buf[head_idx].data;

  assign ld_enq_ready = ~&ld_valid;
  assign ld_enq_fire  = ld_enq_valid & ld_enq_ready;
  assign ld_enq_bmask = bmask(ld_enq_addr[1:0], ld_enq_width);

  always_comb begin
    logic [SP-1:0] offs;
    offs = '0;
    st_col_valid = '0;
    for (int c = 0; c < ST_N_ENTRIES; c++) begin
      offs = SP'(c) - head_idx;
      st_col_valid[c] = ({1'b0, offs} < st_count);
    end
  end

  always_comb begin
    deq_col = '0;
    deq_col[head_idx] = st_deq_fire;
  end

  // Stores leaving this cycle are excluded; a store arriving this cycle is younger.
  always_comb begin
    new_row = '0;
    for (int c = 0; c < ST_N_ENTRIES; c++) begin
      new_row[c] = st_col_valid[c] & ~deq_col[c]
                 & (ld_enq_addr[ADDR_WIDTH-1:2] == st_buf[c].addr[ADDR_WIDTH-1:2])
                 & |(ld_enq_bmask & bmask(st_buf[c].addr[1:0], st_buf[c].width));
    end
  end

  always_comb begin
    ld_free_slot = '0;
    for (int i = LD_N_ENTRIES - 1; i >= 0; i--) begin
      if (!ld_valid[i]) ld_free_slot = LP'(i);
    end
  end

  for (genvar g = 0; g < LD_N_ENTRIES; g++) begin : g_sel
    youngest_dep_sel #(.N(ST_N_ENTRIES), .LW(SP)) u_sel (
      .row   (mdm[g]),
      .tail  (tail_idx),
      .found (y_found[g]),
      .idx   (y_idx[g])
    );
  end

  always_comb begin
    logic [3:0] lm, sm;
    lm = '0;
    sm = '0;
    fwd_ok   = '0;
    ld_ready = '0;
    for (int i = 0; i < LD_N_ENTRIES; i++) begin
      lm = bmask(ld_buf[i].addr[1:0], ld_buf[i].width);
      sm = bmask(st_buf[y_idx[i]].addr[1:0], st_buf[y_idx[i]].width);
      fwd_ok[i]   = FWD_EN & y_found[i] & ((lm & ~sm) == 4'h0);
      ld_ready[i] = ld_valid[i] & ((mdm[i] == '0) | fwd_ok[i]);
    end
  end

  always_comb begin
    iss_sel = '0;
    for (int i = LD_N_ENTRIES - 1; i >= 0; i--) begin
      if (ld_ready[i]) iss_sel = LP'(i);
    end
  end

  assign ld_iss_valid    = |ld_ready;
  assign ld_iss_addr     = ld_buf[iss_sel].addr;
  assign ld_iss_width    = ld_buf[iss_sel].width;
  assign ld_iss_rob_id   = ld_buf[iss_sel].rob_id;
  assign ld_iss_fwd      = ld_iss_valid & fwd_ok[iss_sel] & (mdm[iss_sel] != '0);
  assign ld_iss_fwd_data = ld_iss_fwd ? st_buf[y_idx[iss_sel]].data : 32'h0;
  assign ld_iss_fire     = ld_iss_valid & ld_iss_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ld_valid <= '0;
      st_head  <= '0;
      st_tail  <= '0;
      for (int i = 0; i < LD_N_ENTRIES; i++) mdm[i] <= '0;
    end else begin
      for (int i = 0; i < LD_N_ENTRIES; i++) begin
        if (ld_enq_fire && ld_free_slot == LP'(i)) begin
          ld_valid[i] <= 1'b1;
          mdm[i]      <= new_row;
        end else begin
          if (ld_iss_fire && iss_sel == LP'(i)) ld_valid[i] <= 1'b0;
          mdm[i] <= mdm[i] & ~deq_col;
        end
      end
      if (st_enq_fire) st_tail <= st_tail + 1'b1;
      if (st_deq_fire) st_head <= st_head + 1'b1;
    end
  end

  // Payload storage needs no reset; validity lives in ld_valid and the pointers.
  always_ff @(posedge clk) begin
    if (ld_enq_fire) ld_buf[ld_free_slot] <= '{ld_enq_addr, ld_enq_width, ld_enq_rob_id};
    if (st_enq_fire) st_buf[tail_idx] <= '{st_enq_addr, st_enq_width, st_enq_data};
  end

endmodule

// File: tb/tb_ld_st_dep_tracker.sv
// Bench for ld_st_dep_tracker: directed scenarios then random traffic, every
// cycle compared against a queue-based model of stores and per-load dependency sets.
module tb_ld_st_dep_tracker;

  localparam int LDN = 8;
  localparam int STN = 8;
  localparam bit FWD = 1'b1;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        ld_enq_valid, ld_enq_ready;
  logic [31:0] ld_enq_addr;
  logic [1:0]  ld_enq_width;
  logic [5:0]  ld_enq_rob_id;
  logic        st_enq_valid, st_enq_ready;
  logic [31:0] st_enq_addr;
  logic [1:0]  st_enq_width;
  logic [31:0] st_enq_data;
  logic        st_deq_valid, st_deq_ready;
  logic [31:0] st_deq_addr;
  logic [1:0]  st_deq_width;
  logic [31:0] st_deq_data;
  logic        ld_iss_valid, ld_iss_ready;
  logic [31:0] ld_iss_addr;
  logic [1:0]  ld_iss_width;
  logic [5:0]  ld_iss_rob_id;
  logic        ld_iss_fwd;
  logic [31:0] ld_iss_fwd_data;

  always #5 clk = ~clk;

  ld_st_dep_tracker #(
    .LD_N_ENTRIES(LDN), .ST_N_ENTRIES(STN), .ADDR_WIDTH(32), .ROB_ID_WIDTH(6), .FWD_EN(FWD)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_enq_valid(ld_enq_valid), .ld_enq_ready(ld_enq_ready), .ld_enq_addr(ld_enq_addr),
    .ld_enq_width(ld_enq_width), .ld_enq_rob_id(ld_enq_rob_id),
    .st_enq_valid(st_enq_valid), .st_enq_ready(st_enq_ready), .st_enq_addr(st_enq_addr),
    .st_enq_width(st_enq_width), .st_enq_data(st_enq_data),
    .st_deq_valid(st_deq_valid), .st_deq_ready(st_deq_ready), .st_deq_addr(st_deq_addr),
    .st_deq_width(st_deq_width), .st_deq_data(st_deq_data),
    .ld_iss_valid(ld_iss_valid), .ld_iss_ready(ld_iss_ready), .ld_iss_addr(ld_iss_addr),
    .ld_iss_width(ld_iss_width), .ld_iss_rob_id(ld_iss_rob_id), .ld_iss_fwd(ld_iss_fwd),
    .ld_iss_fwd_data(ld_iss_fwd_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] data;
    int          id;
  } m_st_t;

  m_st_t       sq[$];
  bit          m_lv  [LDN];
  logic [31:0] m_la  [LDN];
  logic [1:0]  m_lw  [LDN];
  logic [5:0]  m_lr  [LDN];
  bit   [63:0] m_dep [LDN];
  int          next_id = 0;

  // Set of byte lanes touched: lanes a .. a+size-1 within the word.
  function automatic logic [3:0] ref_mask(input logic [31:0] a, input logic [1:0] w);
    int sz;
    logic [3:0] m;
    sz = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (b >= int'(a[1:0]) && b < int'(a[1:0]) + sz) m[b] = 1'b1;
    return m;
  endfunction

  function automatic bit overlaps(input logic [31:0] la, input logic [1:0] lw,
                                  input logic [31:0] sa, input logic [1:0] sw);
    return (la[31:2] == sa[31:2]) && ((ref_mask(la, lw) & ref_mask(sa, sw)) != 4'h0);
  endfunction

  function automatic bit covers(input logic [31:0] la, input logic [1:0] lw,
                                input logic [31:0] sa, input logic [1:0] sw);
    return (la[31:2] == sa[31:2]) && ((ref_mask(la, lw) & ~ref_mask(sa, sw)) == 4'h0);
  endfunction

  task automatic model_clear();
    sq.delete();
    for (int s = 0; s < LDN; s++) begin
      m_lv[s]  = 1'b0;
      m_dep[s] = '0;
    end
  endtask

  // Called at a negedge: drive, compare the registered-state outputs, advance model, wait a cycle.
  task automatic step(input bit lv, input logic [31:0] la, input logic [1:0] lw, input logic [5:0] lr,
                      input bit sv, input logic [31:0] sa, input logic [1:0] sw, input logic [31:0] sd,
                      input bit dr, input bit ir, input bit fl);
    int sel, ysel, slot, y, did;
    bit exp_lrdy, ldf, stf, dqf;
    logic [63:0] nd;
    m_st_t e;
    ld_enq_valid = lv; ld_enq_addr = la; ld_enq_width = lw; ld_enq_rob_id = lr;
    st_enq_valid = sv; st_enq_addr = sa; st_enq_width = sw; st_enq_data = sd;
    st_deq_ready = dr; ld_iss_ready = ir; flush = fl;
    #1;
    exp_lrdy = 1'b0;
    slot = -1;
    for (int s = 0; s < LDN; s++)
      if (!m_lv[s]) begin
        exp_lrdy = 1'b1;
        if (slot < 0) slot = s;
      end
    check_val("ld_enq_ready", 64'(ld_enq_ready), 64'(exp_lrdy));
    check_val("st_enq_ready", 64'(st_enq_ready), 64'(sq.size() < STN));
    check_val("st_deq_valid", 64'(st_deq_valid), 64'(sq.size() > 0));
    if (sq.size() > 0) begin
      check_val("st_deq_addr", 64'(st_deq_addr), 64'(sq[0].addr));
      check_val("st_deq_width", 64'(st_deq_width), 64'(sq[0].width));
      check_val("st_deq_data", 64'(st_deq_data), 64'(sq[0].data));
    end
    sel = -1;
    ysel = -1;
    for (int s = 0; s < LDN; s++) begin
      if (m_lv[s] && sel < 0) begin
        y = -1;
        for (int q = sq.size() - 1; q >= 0; q--)
          if (y < 0 && m_dep[s][sq[q].id % 64]) y = q;
        if (y < 0 || (FWD && covers(m_la[s], m_lw[s], sq[y].addr, sq[y].width))) begin
          sel = s;
          ysel = y;
        end
      end
    end
    check_val("ld_iss_valid", 64'(ld_iss_valid), 64'(sel >= 0));
    if (sel >= 0) begin
      check_val("ld_iss_addr", 64'(ld_iss_addr), 64'(m_la[sel]));
      check_val("ld_iss_width", 64'(ld_iss_width), 64'(m_lw[sel]));
      check_val("ld_iss_rob_id", 64'(ld_iss_rob_id), 64'(m_lr[sel]));
      check_val("ld_iss_fwd", 64'(ld_iss_fwd), 64'(ysel >= 0));
      if (ysel >= 0) check_val("ld_iss_fwd_data", 64'(ld_iss_fwd_data), 64'(sq[ysel].data));
    end else begin
      check_val("ld_iss_fwd_idle", 64'(ld_iss_fwd), 64'(0));
    end
    if (fl) begin
      model_clear();
    end else begin
      ldf = lv && exp_lrdy;
      stf = sv && (sq.size() < STN);
      dqf = dr && (sq.size() > 0);
      nd = '0;
      if (ldf)
        for (int q = (dqf ? 1 : 0); q < sq.size(); q++)
          if (overlaps(la, lw, sq[q].addr, sq[q].width)) nd[sq[q].id % 64] = 1'b1;
      if (sel >= 0 && ir) m_lv[sel] = 1'b0;
      if (ldf) begin
        m_lv[slot] = 1'b1; m_la[slot] = la; m_lw[slot] = lw; m_lr[slot] = lr; m_dep[slot] = nd;
      end
      if (dqf) begin
        did = sq[0].id % 64;
        for (int s = 0; s < LDN; s++) m_dep[s][did] = 1'b0;
        void'(sq.pop_front());
      end
      if (stf) begin
        e.addr = sa; e.width = sw; e.data = sd; e.id = next_id;
        next_id++;
        sq.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit dr, input bit ir);
    step(1'b0, 32'h0, 2'b00, 6'd0, 1'b0, 32'h0, 2'b00, 32'h0, dr, ir, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, sa;
    logic [1:0]  rw, sw;
    rst = 1'b1; flush = 1'b0;
    ld_enq_valid = 0; ld_enq_addr = 0; ld_enq_width = 0; ld_enq_rob_id = 0;
    st_enq_valid = 0; st_enq_addr = 0; st_enq_width = 0; st_enq_data = 0;
    st_deq_ready = 0; ld_iss_ready = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // plain load, no stores
    step(1, 32'h100, 2'b10, 6'd5, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 1);
    // full-coverage forward
    step(0, 0, 0, 0, 1, 32'h100, 2'b10, 32'hDEADBEEF, 0, 0, 0);
    step(1, 32'h100, 2'b10, 6'd7, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 1);
    idle(1, 0);
    // partial coverage: wait for drain
    step(0, 0, 0, 0, 1, 32'h102, 2'b01, 32'h1234_0000, 0, 0, 0);
    step(1, 32'h100, 2'b10, 6'd9, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 1);
    idle(1, 1);
    idle(0, 1);
    // fill FIFO, refused enq on simultaneous deq, then wrap traffic
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, 32'h200 + 32'(4 * k), 2'b10, 32'hA000 + 32'(k), 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h300, 2'b10, 32'hBAD0, 1, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 1, 32'h240 + 32'(4 * k), 2'b10, 32'hC000 + 32'(k), k % 3 != 2, 0, 0);
    repeat (10) idle(1, 0);
    // same-cycle store enq and store deq do not create dependencies
    step(1, 32'h400, 2'b10, 6'd11, 1, 32'h400, 2'b10, 32'hCAFEF00D, 0, 1, 0);
    idle(0, 1);
    step(1, 32'h400, 2'b10, 6'd12, 0, 0, 0, 0, 1, 0, 0);
    idle(0, 0);
    idle(0, 1);
    // flush with resident loads and stores wins over same-cycle traffic
    for (int k = 0; k < 4; k++) step(k < 3, 32'h500, 2'b10, 6'(20 + k), 1, 32'h500, 2'b01, 32'h77 + 32'(k), 0, 0, 0);
    step(1, 32'h500, 2'b10, 6'd30, 1, 32'h500, 2'b10, 32'h99, 1, 1, 1);
    idle(0, 0);

    for (int n = 0; n < 3000; n++) begin
      rw = 2'($urandom_range(0, 2));
      ra = 32'h100 + 32'(4 * $urandom_range(0, 1));
      ra[1:0] = (rw == 2'b00) ? 2'($urandom_range(0, 3)) : (rw == 2'b01) ? 2'(2 * $urandom_range(0, 1)) : 2'b00;
      sw = 2'($urandom_range(0, 2));
      sa = 32'h100 + 32'(4 * $urandom_range(0, 1));
      sa[1:0] = (sw == 2'b00) ? 2'($urandom_range(0, 3)) : (sw == 2'b01) ? 2'(2 * $urandom_range(0, 1)) : 2'b00;
      step(1'($urandom_range(0, 1)), ra, rw, 6'($urandom), 1'($urandom_range(0, 1)), sa, sw, $urandom,
           $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    end
    idle(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
